// File: rtl/mult32u_share_arbiter.sv
// Round-robin front end for one shared pipelined 32x32 unsigned multiplier.
// Grants at most one requester per cycle. The grant's ID travels down a tag pipeline
// that is as deep as the multiplier latency. When the tag leaves the pipeline, the
// product on mul_p_i is returned to the requester that issued the operation.
module mult32u_share_arbiter #(
  parameter int unsigned NumReq  = 4,
  parameter int unsigned Latency = 2,
  parameter int unsigned IdW     = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           hold_i,
  input  logic [NumReq-1:0]              req_valid_i,
  output logic [NumReq-1:0]              req_ready_o,
  input  logic [NumReq*32-1:0]           req_a_i,
  input  logic [NumReq*32-1:0]           req_b_i,
  output logic [31:0]                    mul_a_o,
  output logic [31:0]                    mul_b_o,
  input  logic [63:0]                    mul_p_i,
  output logic [NumReq-1:0]              rsp_valid_o,
  output logic [IdW-1:0]                 rsp_id_o,
  output logic [63:0]                    rsp_product_o,
  output logic [$clog2(Latency+1)-1:0]   inflight_o
);

  localparam int unsigned InflW = $clog2(Latency + 1);

  logic [IdW-1:0]                rr_ptr_q, rr_ptr_d;
  logic [Latency-1:0]            tag_vld_q, tag_vld_d;
  logic [Latency-1:0][IdW-1:0]   tag_id_q, tag_id_d;
  logic [InflW-1:0]              inflight_q, inflight_d;

  logic           grant_found;
  logic [IdW-1:0] grant_id;
  logic           fire;
  logic           rsp_fire;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      if (!grant_found && req_valid_i[(32'(rr_ptr_q) + k) % NumReq]) begin
        grant_found = 1'b1;
        grant_id    = IdW'((32'(rr_ptr_q) + k) % NumReq);
      end
    end
  end

  assign fire        = grant_found & ~hold_i & ~rst_i;
  assign req_ready_o = fire ? (NumReq'(1) << grant_id) : '0;

  // Operand mux; zero when idle so the multiplier registers see a quiet bus.
  always_comb begin
    mul_a_o = '0;
    mul_b_o = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (fire && (grant_id == IdW'(i))) begin
        mul_a_o = req_a_i[32*i +: 32];
        mul_b_o = req_b_i[32*i +: 32];
      end
    end
  end

  // Pointer moves just past the winner; it stays frozen when nothing issues.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (fire) begin
      rr_ptr_d = (grant_id == IdW'(NumReq - 1)) ? '0 : grant_id + IdW'(1);
    end
  end

  // Tag pipeline shifts every cycle; the multiplier has no back-pressure.
  always_comb begin
    tag_vld_d    = tag_vld_q;
    tag_id_d     = tag_id_q;
    tag_vld_d[0] = fire;
    tag_id_d[0]  = grant_id;
    for (int unsigned k = 1; k < Latency; k++) begin
      tag_vld_d[k] = tag_vld_q[k-1];
      tag_id_d[k]  = tag_id_q[k-1];
    end
  end

  // Reset masks a tag that is in the last stage, so discarded ops never pulse.
  assign rsp_fire      = tag_vld_q[Latency-1] & ~rst_i;
  assign rsp_valid_o   = rsp_fire ? (NumReq'(1) << tag_id_q[Latency-1]) : '0;
  assign rsp_id_o      = rsp_fire ? tag_id_q[Latency-1] : '0;
  assign rsp_product_o = mul_p_i;

  // Outstanding-op count: an issue and a return in the same cycle cancel out.
  always_comb begin
    inflight_d = inflight_q;
    case ({fire, rsp_fire})
      2'b10:   inflight_d = inflight_q + InflW'(1);
      2'b01:   inflight_d = inflight_q - InflW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  assign inflight_o = inflight_q;

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q   <= '0;
      tag_vld_q  <= '0;
      tag_id_q   <= '0;
      inflight_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      tag_vld_q  <= tag_vld_d;
      tag_id_q   <= tag_id_d;
      inflight_q <= inflight_d;
    end
  end

endmodule

// File: tb/tb_mult32u_share_arbiter.sv
// Bench for mult32u_share_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based reference model.
module tb_mult32u_share_arbiter;

  localparam int NR  = 4;
  localparam int LAT = 2;
  localparam int IW  = 2;
  localparam int FW  = $clog2(LAT + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              hold;
  logic [NR-1:0]     valid;
  logic [NR-1:0]     ready;
  logic [NR*32-1:0]  ra, rb;
  logic [31:0]       mul_a, mul_b;
  logic [63:0]       mul_p;
  logic [NR-1:0]     rsp_valid;
  logic [IW-1:0]     rsp_id;
  logic [63:0]       rsp_product;
  logic [FW-1:0]     inflight;

  int nchecks = 0;
  int nfail   = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  mult32u_share_arbiter #(
    .NumReq (NR),
    .Latency(LAT),
    .IdW    (IW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .hold_i       (hold),
    .req_valid_i  (valid),
    .req_ready_o  (ready),
    .req_a_i      (ra),
    .req_b_i      (rb),
    .mul_a_o      (mul_a),
    .mul_b_o      (mul_b),
    .mul_p_i      (mul_p),
    .rsp_valid_o  (rsp_valid),
    .rsp_id_o     (rsp_id),
    .rsp_product_o(rsp_product),
    .inflight_o   (inflight)
  );

  // Stand-in multiplier: registered operands, registered product (latency 2).
  logic [31:0] ma_q, mb_q;
  logic [63:0] p_q;
  always @(posedge clk) begin
    ma_q <= mul_a;
    mb_q <= mul_b;
    p_q  <= 64'(ma_q) * 64'(mb_q);
  end
  assign mul_p = p_q;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: pointer, plus a queue of outstanding ops with their due cycle.
  typedef struct {
    int          due;
    int          id;
    logic [63:0] prod;
  } pend_t;

  pend_t          q[$];
  pend_t          ent;
  int             m_ptr = 0;
  int             g_id;
  bit             g_found;
  bit             r_due;
  logic [NR-1:0]  e_ready, e_rv;
  logic [31:0]    e_a, e_b;

  always @(negedge clk) begin
    g_found = 1'b0;
    g_id    = 0;
    if (!rst && !hold) begin
      for (int k = 0; k < NR; k++) begin
        if (!g_found && valid[(m_ptr + k) % NR]) begin
          g_found = 1'b1;
          g_id    = (m_ptr + k) % NR;
        end
      end
    end
    e_ready = g_found ? NR'(1) << g_id : '0;
    e_a     = g_found ? ra[32*g_id +: 32] : 32'd0;
    e_b     = g_found ? rb[32*g_id +: 32] : 32'd0;
    r_due   = !rst && (q.size() > 0) && (q[0].due == cyc);
    e_rv    = r_due ? NR'(1) << q[0].id : '0;

    chk("req_ready", 64'(ready), 64'(e_ready));
    chk("mul_a", 64'(mul_a), 64'(e_a));
    chk("mul_b", 64'(mul_b), 64'(e_b));
    chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
    chk("rsp_id", 64'(rsp_id), r_due ? 64'(q[0].id) : 64'd0);
    chk("inflight", 64'(inflight), 64'(q.size()));
    if (r_due) chk("rsp_product", rsp_product, q[0].prod);

    if (rst) begin
      q.delete();
      m_ptr = 0;
    end else begin
      if (r_due) void'(q.pop_front());
      if (g_found) begin
        ent.due  = cyc + LAT;
        ent.id   = g_id;
        ent.prod = 64'(e_a) * 64'(e_b);
        q.push_back(ent);
        m_ptr = (g_id + 1) % NR;
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    ra[32*i +: 32] = a;
    rb[32*i +: 32] = b;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 3))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  logic [NR-1:0] grant_tbl [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                   4'b0001, 4'b0010, 4'b0100, 4'b1000};

  initial begin
    rst = 1'b1; hold = 1'b0; valid = '0; ra = '0; rb = '0;
    tick(); tick();
    rst = 1'b0;

    // Single op from requester 0.
    set_op(0, 32'd3, 32'd5); valid = 4'b0001;
    @(negedge clk); chk("t1_ready", 64'(ready), 64'h1);
    tick(); valid = '0;
    @(negedge clk); chk("t1_inflight1", 64'(inflight), 64'd1);
    tick();
    @(negedge clk);
    chk("t1_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("t1_product", rsp_product, 64'd15);
    chk("t1_inflight2", 64'(inflight), 64'd1);
    tick();
    @(negedge clk); chk("t1_inflight0", 64'(inflight), 64'd0);

    // Maximum operands.
    tick(); set_op(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF); valid = 4'b0100;
    @(negedge clk); chk("t3_ready", 64'(ready), 64'h4);
    tick(); valid = '0;
    tick();
    @(negedge clk);
    chk("t3_rsp_valid", 64'(rsp_valid), 64'h4);
    chk("t3_product", rsp_product, 64'hFFFF_FFFE_0000_0001);

    // All requesters valid continuously after a reset.
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NR; i++) set_op(i, $urandom, $urandom);
      @(negedge clk);
      chk("t2_grant", 64'(ready), 64'(grant_tbl[k]));
      if (k >= LAT) chk("t2_rsp_id", 64'(rsp_id), 64'((k - LAT) % NR));
      tick();
    end

    // Hold for three cycles while two ops are in flight.
    valid = 4'b0010; hold = 1'b1;
    @(negedge clk);
    chk("t4_inflight", 64'(inflight), 64'd2);
    chk("t4_ready_h0", 64'(ready), 64'h0);
    chk("t4_rsp_h0", 64'(rsp_valid), 64'h4);
    tick();
    @(negedge clk);
    chk("t4_ready_h1", 64'(ready), 64'h0);
    chk("t4_rsp_h1", 64'(rsp_valid), 64'h8);
    tick();
    @(negedge clk);
    chk("t4_ready_h2", 64'(ready), 64'h0);
    tick(); hold = 1'b0;
    @(negedge clk); chk("t4_ready_after", 64'(ready), 64'h2);

    // Reset one cycle after an issue discards the op.
    tick(); valid = 4'b0100;
    tick(); valid = '0; rst = 1'b1;
    tick(); rst = 1'b0; valid = 4'b1111;
    @(negedge clk);
    chk("t5_ready", 64'(ready), 64'h1);
    chk("t5_no_rsp", 64'(rsp_valid), 64'h0);
    chk("t5_inflight", 64'(inflight), 64'd0);

    // Wrap-around: bring rr_ptr to 3, then req3 alone, then req0 and req3.
    tick(); valid = 4'b0010;
    tick(); valid = 4'b0100;
    tick(); valid = 4'b1000;
    @(negedge clk); chk("t6_ready_3", 64'(ready), 64'h8);
    tick(); valid = 4'b1001;
    @(negedge clk); chk("t6_ready_0", 64'(ready), 64'h1);
    tick(); valid = '0;

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      tick();
      rst   = ($urandom_range(0, 49) == 0);
      hold  = ($urandom_range(0, 7) == 0);
      valid = NR'($urandom);
      for (int i = 0; i < NR; i++) set_op(i, pick_operand(), pick_operand());
    end

    tick(); rst = 1'b0; hold = 1'b0; valid = '0;
    repeat (LAT + 2) tick();
    @(negedge clk);
    chk("drained", 64'(q.size()), 64'd0);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

endmodule
